ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
Execute stage of the 5-stage MIPS pipeline. It consumes the ID/EX pipeline register outputs and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It computes the ALU result, selects the destination register and captures everything into the EX/MEM pipeline register that feeds the memory stage.

Parameters:
WIDTH, 32, datapath width (fixed at 32 in this design; parameter only for bench reuse)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
regWrite_IDEX  in  1  register-write control from ID/EX
ALUSrc_IDEX  in  1  1 = operand B is sign-extended immediate
regDst_IDEX  in  1  1 = destination is Rd, 0 = Rt
memWrite_IDEX  in  1  store control
memRead_IDEX  in  1  load control
memtoReg_IDEX  in  1  writeback-select control
ALUop_IDEX  in  3  ALU operation from ID/EX
Rs_IDEX, Rt_IDEX, Rd_IDEX  in  5 each  register numbers from ID/EX
data1_IDEX, data2_IDEX, SEData_IDEX  in  32 each  register operands and immediate
regWrite_MEMWB  in  1  MEM/WB write enable
writeReg_MEMWB  in  5  MEM/WB destination
writeData_MEMWB  in  32  MEM/WB writeback value
out_reg_regWrite_EXMEM, out_reg_memWrite_EXMEM, out_reg_memRead_EXMEM, out_reg_memtoReg_EXMEM  out  1 each  registered controls
out_reg_zero_EXMEM  out  1  registered ALU zero flag
out_reg_writeReg_EXMEM  out  5  registered destination register
out_reg_ALUres_EXMEM  out  32  registered ALU result (memory address for ld/st)
out_reg_writeData_EXMEM  out  32  registered store data (forwarded operand B before the ALUSrc mux)
forwardA, forwardB  out  2 each  combinational forwarding selects, for visibility and debug

Behaviour:
- One clock, one synchronous active-high reset (rst). All EX/MEM registers load every cycle. There is no stall input; load-use stalls are handled upstream by bubbling the ID/EX controls.
- Reset: every out_reg_* output is 0 on the first rising edge with rst=1. Reset has priority over load. Asserting rst mid-stream discards the in-flight instruction; its regWrite/memWrite never reach MEM.
- Forward select for A (same rule for B using Rt_IDEX):
  - 2'b10 if out_reg_regWrite_EXMEM & out_reg_writeReg_EXMEM!=0 & out_reg_writeReg_EXMEM==Rs_IDEX.
  - else 2'b01 if regWrite_MEMWB & writeReg_MEMWB!=0 & writeReg_MEMWB==Rs_IDEX.
  - else 2'b00.
  - EX/MEM has priority when both stages match.
  - 2'b11 never occurs.
- Operand mux: 00 selects data1/data2_IDEX, 10 selects out_reg_ALUres_EXMEM, 01 selects writeData_MEMWB.
- Operand B = ALUSrc_IDEX ? SEData_IDEX : forwarded B.
- Store data = forwarded B, regardless of ALUSrc.
- ALU ops:
  - 000 AND; 001 OR; 010 ADD; 110 SUB.
  - 111 SLT: signed compare, result is 32'h1 or 32'h0.
  - 011, 100, 101: result 0.
  - ADD/SUB wrap modulo 2^32; no overflow exception.
- zero = (ALU result == 0).
- Destination = regDst_IDEX ? Rd_IDEX : Rt_IDEX.
- Bubble pass-through: with all ID/EX controls 0, the EX/MEM controls are 0 the next cycle. Data fields are don't-care.
- Latency: exactly one cycle from ID/EX values to out_reg_* outputs.
- Forwarding of a load result from EX/MEM is not special-cased. The upstream hazard unit guarantees no load-use dependency reaches this stage unstalled.

Test Plan:
- rst=1 for 2 cycles with nonzero inputs -> all out_reg_* = 0. Release rst, then ADD with data1=5, data2=7, regDst=1, Rd=3 -> next cycle ALUres=12, writeReg=3, regWrite=1, zero=0.
- SUB 9-9 -> ALUres=0, zero=1. SLT with data1=32'hFFFFFFFF (-1), data2=1 -> ALUres=1. ADD 32'hFFFFFFFF+1 -> ALUres=0, zero=1.
- Back-to-back dependency: instr1 writes $2=10 (in EX/MEM). Instr2 has Rs=2, data1_IDEX stale=0, adds 4 -> forwardA=10, ALUres=14. Repeat with the producer in MEM/WB only (writeData_MEMWB=20) -> forwardA=01, ALUres=24.
- Double hazard: EX/MEM writes $4=1 and MEM/WB writes $4=2; consumer uses Rs=Rt=4 -> forwardA=forwardB=10, ADD result=2. Any producer writing $0 -> forward=00.
- Store with ALUSrc=1, SEData=8, data1=100, Rt forwarded from EX/MEM=55 -> ALUres=108, writeData=55, memWrite=1.
- Bubble (all controls 0) followed by rst asserted during an in-flight ADD with regWrite=1 -> EX/MEM controls 0 on both edges.

Source files
------------

// File: rtl/ex_mem_stage.sv
// Execute stage: RAW forwarding from EX/MEM and MEM/WB, ALU, destination select, EX/MEM register.
// Latency 1 cycle; no backpressure (no stall input, the register loads every cycle).
module ex_mem_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regWrite_IDEX,
    input  logic             ALUSrc_IDEX,
    input  logic             regDst_IDEX,
    input  logic             memWrite_IDEX,
    input  logic             memRead_IDEX,
    input  logic             memtoReg_IDEX,
    input  logic [2:0]       ALUop_IDEX,
    input  logic [4:0]       Rs_IDEX,
    input  logic [4:0]       Rt_IDEX,
    input  logic [4:0]       Rd_IDEX,
    input  logic [WIDTH-1:0] data1_IDEX,
    input  logic [WIDTH-1:0] data2_IDEX,
    input  logic [WIDTH-1:0] SEData_IDEX,
    input  logic             regWrite_MEMWB,
    input  logic [4:0]       writeReg_MEMWB,
    input  logic [WIDTH-1:0] writeData_MEMWB,
    output logic             out_reg_regWrite_EXMEM,
    output logic             out_reg_memWrite_EXMEM,
    output logic             out_reg_memRead_EXMEM,
    output logic             out_reg_memtoReg_EXMEM,
    output logic             out_reg_zero_EXMEM,
    output logic [4:0]       out_reg_writeReg_EXMEM,
    output logic [WIDTH-1:0] out_reg_ALUres_EXMEM,
    output logic [WIDTH-1:0] out_reg_writeData_EXMEM,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB
);

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic             reg_write_q, reg_write_d;
    logic             mem_write_q, mem_write_d;
    logic             mem_read_q,  mem_read_d;
    logic             mem_to_reg_q, mem_to_reg_d;
    logic             zero_q,      zero_d;
    logic [4:0]       write_reg_q, write_reg_d;
    logic [WIDTH-1:0] alu_res_q,   alu_res_d;
    logic [WIDTH-1:0] write_data_q, write_data_d;

    fwd_sel_e         fwd_a, fwd_b;
    logic [WIDTH-1:0] op_a, fwd_b_val, op_b;

    // The younger producer (EX/MEM) wins over MEM/WB; $0 is never forwarded.
    function automatic fwd_sel_e fwd_select(
        input logic       exmem_wr,
        input logic [4:0] exmem_reg,
        input logic       memwb_wr,
        input logic [4:0] memwb_reg,
        input logic [4:0] src
    );
        if (exmem_wr && (exmem_reg != 5'd0) && (exmem_reg == src)) begin
            return FWD_EXMEM;
        end else if (memwb_wr && (memwb_reg != 5'd0) && (memwb_reg == src)) begin
            return FWD_MEMWB;
        end
        return FWD_REG;
    endfunction

    always_comb begin
        fwd_a = fwd_select(reg_write_q, write_reg_q, regWrite_MEMWB, writeReg_MEMWB, Rs_IDEX);
        fwd_b = fwd_select(reg_write_q, write_reg_q, regWrite_MEMWB, writeReg_MEMWB, Rt_IDEX);

        case (fwd_a)
            FWD_EXMEM: op_a = alu_res_q;
            FWD_MEMWB: op_a = writeData_MEMWB;
            default:   op_a = data1_IDEX;
        endcase

        case (fwd_b)
            FWD_EXMEM: fwd_b_val = alu_res_q;
            FWD_MEMWB: fwd_b_val = writeData_MEMWB;
            default:   fwd_b_val = data2_IDEX;
        endcase

        op_b = ALUSrc_IDEX ? SEData_IDEX : fwd_b_val;
    end

    always_comb begin
        alu_res_d = '0;
        case (ALUop_IDEX)
            ALU_AND: alu_res_d = op_a & op_b;
            ALU_OR:  alu_res_d = op_a | op_b;
            ALU_ADD: alu_res_d = op_a + op_b;
            ALU_SUB: alu_res_d = op_a - op_b;
            ALU_SLT: alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_res_d = '0;
        endcase
    end

    always_comb begin
        reg_write_d  = regWrite_IDEX;
        mem_write_d  = memWrite_IDEX;
        mem_read_d   = memRead_IDEX;
        mem_to_reg_d = memtoReg_IDEX;
        zero_d       = (alu_res_d == '0);
        write_reg_d  = regDst_IDEX ? Rd_IDEX : Rt_IDEX;
        // Store data bypasses the immediate mux so sw gets the register value.
        write_data_d = fwd_b_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_to_reg_q <= 1'b0;
            zero_q       <= 1'b0;
            write_reg_q  <= '0;
            alu_res_q    <= '0;
            write_data_q <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            mem_to_reg_q <= mem_to_reg_d;
            zero_q       <= zero_d;
            write_reg_q  <= write_reg_d;
            alu_res_q    <= alu_res_d;
            write_data_q <= write_data_d;
        end
    end

    assign out_reg_regWrite_EXMEM  = reg_write_q;
    assign out_reg_memWrite_EXMEM  = mem_write_q;
    assign out_reg_memRead_EXMEM   = mem_read_q;
    assign out_reg_memtoReg_EXMEM  = mem_to_reg_q;
    assign out_reg_zero_EXMEM      = zero_q;
    assign out_reg_writeReg_EXMEM  = write_reg_q;
    assign out_reg_ALUres_EXMEM    = alu_res_q;
    assign out_reg_writeData_EXMEM = write_data_q;
    assign forwardA                = fwd_a;
    assign forwardB                = fwd_b;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed hazard/ALU cases plus random traffic against a scoreboard.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        regWrite_IDEX, ALUSrc_IDEX, regDst_IDEX;
    logic        memWrite_IDEX, memRead_IDEX, memtoReg_IDEX;
    logic [2:0]  ALUop_IDEX;
    logic [4:0]  Rs_IDEX, Rt_IDEX, Rd_IDEX;
    logic [31:0] data1_IDEX, data2_IDEX, SEData_IDEX;
    logic        regWrite_MEMWB;
    logic [4:0]  writeReg_MEMWB;
    logic [31:0] writeData_MEMWB;
    logic        out_reg_regWrite_EXMEM, out_reg_memWrite_EXMEM;
    logic        out_reg_memRead_EXMEM, out_reg_memtoReg_EXMEM, out_reg_zero_EXMEM;
    logic [4:0]  out_reg_writeReg_EXMEM;
    logic [31:0] out_reg_ALUres_EXMEM, out_reg_writeData_EXMEM;
    logic [1:0]  forwardA, forwardB;

    always #5 clk = ~clk;

    ex_mem_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .regWrite_IDEX(regWrite_IDEX), .ALUSrc_IDEX(ALUSrc_IDEX), .regDst_IDEX(regDst_IDEX),
        .memWrite_IDEX(memWrite_IDEX), .memRead_IDEX(memRead_IDEX), .memtoReg_IDEX(memtoReg_IDEX),
        .ALUop_IDEX(ALUop_IDEX), .Rs_IDEX(Rs_IDEX), .Rt_IDEX(Rt_IDEX), .Rd_IDEX(Rd_IDEX),
        .data1_IDEX(data1_IDEX), .data2_IDEX(data2_IDEX), .SEData_IDEX(SEData_IDEX),
        .regWrite_MEMWB(regWrite_MEMWB), .writeReg_MEMWB(writeReg_MEMWB),
        .writeData_MEMWB(writeData_MEMWB),
        .out_reg_regWrite_EXMEM(out_reg_regWrite_EXMEM),
        .out_reg_memWrite_EXMEM(out_reg_memWrite_EXMEM),
        .out_reg_memRead_EXMEM(out_reg_memRead_EXMEM),
        .out_reg_memtoReg_EXMEM(out_reg_memtoReg_EXMEM),
        .out_reg_zero_EXMEM(out_reg_zero_EXMEM),
        .out_reg_writeReg_EXMEM(out_reg_writeReg_EXMEM),
        .out_reg_ALUres_EXMEM(out_reg_ALUres_EXMEM),
        .out_reg_writeData_EXMEM(out_reg_writeData_EXMEM),
        .forwardA(forwardA), .forwardB(forwardB)
    );

    typedef struct {
        logic        rw, mw, mr, mt, z;
        logic [4:0]  wreg;
        logic [31:0] res, wdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference view of the EX/MEM register contents.
    logic        m_rw, m_known;
    logic [4:0]  m_reg;
    logic [31:0] m_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [1:0] mfwd(input logic [4:0] src, input logic wbw, input logic [4:0] wbr);
        if (m_rw && m_reg != 5'd0 && m_reg == src) return 2'b10;
        if (wbw && wbr != 5'd0 && wbr == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic drain();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("regWrite", 64'(out_reg_regWrite_EXMEM), 64'(e.rw));
            chk("memWrite", 64'(out_reg_memWrite_EXMEM), 64'(e.mw));
            chk("memRead",  64'(out_reg_memRead_EXMEM),  64'(e.mr));
            chk("memtoReg", 64'(out_reg_memtoReg_EXMEM), 64'(e.mt));
            chk("zero",     64'(out_reg_zero_EXMEM),     64'(e.z));
            chk("writeReg", 64'(out_reg_writeReg_EXMEM), 64'(e.wreg));
            chk("ALUres",   64'(out_reg_ALUres_EXMEM),   64'(e.res));
            chk("writeData",64'(out_reg_writeData_EXMEM),64'(e.wdata));
        end
    endtask

    task automatic issue(
        input logic r, input logic rw, input logic src, input logic dst,
        input logic mw, input logic mr, input logic mt, input logic [2:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] se,
        input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd
    );
        exp_t        e;
        logic [1:0]  fa, fb;
        logic [31:0] a, bf, b;
        @(negedge clk);
        drain();
        rst = r; regWrite_IDEX = rw; ALUSrc_IDEX = src; regDst_IDEX = dst;
        memWrite_IDEX = mw; memRead_IDEX = mr; memtoReg_IDEX = mt; ALUop_IDEX = op;
        Rs_IDEX = rs; Rt_IDEX = rt; Rd_IDEX = rd;
        data1_IDEX = d1; data2_IDEX = d2; SEData_IDEX = se;
        regWrite_MEMWB = wbw; writeReg_MEMWB = wbr; writeData_MEMWB = wbd;
        #1;
        fa = mfwd(rs, wbw, wbr);
        fb = mfwd(rt, wbw, wbr);
        if (m_known) begin
            chk("forwardA", 64'(forwardA), 64'(fa));
            chk("forwardB", 64'(forwardB), 64'(fb));
        end
        a  = (fa == 2'b10) ? m_res : (fa == 2'b01) ? wbd : d1;
        bf = (fb == 2'b10) ? m_res : (fb == 2'b01) ? wbd : d2;
        b  = src ? se : bf;
        if (r) begin
            e = '{rw: 1'b0, mw: 1'b0, mr: 1'b0, mt: 1'b0, z: 1'b0, wreg: 5'd0, res: 32'd0, wdata: 32'd0};
        end else begin
            e.rw = rw; e.mw = mw; e.mr = mr; e.mt = mt;
            e.res = alu(op, a, b);
            e.z = (e.res == 32'd0);
            e.wreg = dst ? rd : rt;
            e.wdata = bf;
        end
        sb.push_back(e);
        if (r) m_known = 1'b1;
        m_rw = e.rw; m_reg = e.wreg; m_res = e.res;
    endtask

    // Plain ALU instruction, register destination Rd, no MEM/WB activity.
    task automatic alu_op(input logic rw, input logic [2:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2);
        issue(0, rw, 0, 1, 0, 0, 0, op, rs, rt, rd, d1, d2, 32'd0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        m_known = 1'b0; m_rw = 1'b0; m_reg = '0; m_res = '0;
        // Reset with busy, nonzero inputs.
        issue(1, 1, 1, 1, 1, 1, 1, 3'b010, 5'd7, 5'd8, 5'd9, 32'hAA, 32'hBB, 32'hCC, 1, 5'd7, 32'h55);
        issue(1, 1, 0, 1, 1, 1, 1, 3'b001, 5'd7, 5'd8, 5'd9, 32'hAA, 32'hBB, 32'hCC, 1, 5'd8, 32'h55);
        // ALU basics.
        alu_op(1, 3'b010, 5'd10, 5'd11, 5'd3, 32'd5, 32'd7);
        alu_op(0, 3'b110, 5'd10, 5'd11, 5'd12, 32'd9, 32'd9);
        alu_op(0, 3'b111, 5'd10, 5'd11, 5'd12, 32'hFFFFFFFF, 32'd1);
        alu_op(0, 3'b010, 5'd10, 5'd11, 5'd12, 32'hFFFFFFFF, 32'd1);
        alu_op(0, 3'b000, 5'd10, 5'd11, 5'd12, 32'hF0F0F0F0, 32'hFF00FF00);
        alu_op(0, 3'b011, 5'd10, 5'd11, 5'd12, 32'h12345678, 32'h1);
        // EX/MEM forward, then MEM/WB-only forward.
        alu_op(1, 3'b010, 5'd10, 5'd11, 5'd2, 32'd6, 32'd4);
        issue(0, 0, 1, 1, 0, 0, 0, 3'b010, 5'd2, 5'd13, 5'd14, 32'd0, 32'd0, 32'd4, 0, 5'd0, 32'd0);
        issue(0, 0, 1, 1, 0, 0, 0, 3'b010, 5'd2, 5'd13, 5'd14, 32'd0, 32'd0, 32'd4, 1, 5'd2, 32'd20);
        // Double hazard on $4, EX/MEM wins.
        alu_op(1, 3'b010, 5'd10, 5'd11, 5'd4, 32'd1, 32'd0);
        issue(0, 0, 0, 1, 0, 0, 0, 3'b010, 5'd4, 5'd4, 5'd14, 32'd0, 32'd0, 32'd0, 1, 5'd4, 32'd2);
        // Writes to $0 are never forwarded.
        alu_op(1, 3'b010, 5'd10, 5'd11, 5'd0, 32'd90, 32'd9);
        issue(0, 0, 0, 1, 0, 0, 0, 3'b001, 5'd0, 5'd0, 5'd14, 32'h3, 32'h4, 32'd0, 1, 5'd0, 32'h77);
        // Store: address from immediate, data forwarded from EX/MEM.
        alu_op(1, 3'b010, 5'd10, 5'd11, 5'd5, 32'd50, 32'd5);
        issue(0, 0, 1, 0, 1, 0, 0, 3'b010, 5'd1, 5'd5, 5'd0, 32'd100, 32'd0, 32'd8, 0, 5'd0, 32'd0);
        // Bubble, then reset squashing an in-flight write.
        issue(0, 0, 0, 0, 0, 0, 0, 3'b010, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd3, 0, 5'd0, 32'd0);
        issue(1, 1, 0, 1, 0, 0, 0, 3'b010, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd3, 0, 5'd0, 32'd0);
        // Random traffic with a small register set to provoke hazards.
        for (int i = 0; i < 300; i++) begin
            issue(($urandom_range(0, 24) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                  5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                  $urandom, 1'($urandom), 5'($urandom_range(0, 5)), $urandom);
        end
        @(negedge clk);
        drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
